seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider for the MIPS datapath's DIV/DIVU path. It replaces the fixed 16-bit shift-register divider with a self-contained unit: one quotient bit per clock, start/busy/done handshake, and signed and unsigned modes. It also handles divide-by-zero and signed overflow explicitly. It sits beside the ALU and writes HI/LO-style results (quotient, remainder) back through the result mux when `done` pulses.

---
 rtl/seq_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned,
// explicit divide-by-zero and signed-overflow reporting.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     part_q, part_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               ovf_pend_q, ovf_pend_d;

  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     part_sh;
  logic [WIDTH:0]     part_sub;
  logic               fits;

  function automatic logic [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] x);
    return $unsigned(-x);
  endfunction

  // |most-negative| wraps to 2^(WIDTH-1), which is exactly right as an unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));
  assign part_sh   = {part_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign part_sub  = part_sh - {1'b0, dvs_q};
  assign fits      = (part_sh >= {1'b0, dvs_q});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    count_q    <= count_d;
    dvd_raw_q  <= dvd_raw_d;
    dvd_q      <= dvd_d;
    dvs_q      <= dvs_d;
    part_q     <= part_d;
    quo_q      <= quo_d;
    neg_q_q    <= neg_q_d;
    neg_r_q    <= neg_r_d;
    ovf_pend_q <= ovf_pend_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (divisor == '0) ? FIX : RUN;
      RUN:  if (last_iter) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    dvd_raw_d  = dvd_raw_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    part_d     = part_q;
    quo_d      = quo_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    ovf_pend_d = ovf_pend_q;
    if (accept) begin
      count_d    = '0;
      dvd_raw_d  = dividend;
      dvd_d      = magnitude(dividend, signed_op);
      dvs_d      = magnitude(divisor, signed_op);
      part_d     = '0;
      quo_d      = '0;
      neg_q_d    = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_d    = signed_op && dividend[WIDTH-1];
      ovf_pend_d = signed_op && (dividend == MOST_NEG) && (divisor == '1);
    end else if (state_q == RUN) begin
      count_d = count_q + 1'b1;
      dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
      part_d  = fits ? part_sub : part_sh;
      quo_d   = {quo_q[WIDTH-2:0], fits};
    end
  end

  // Output logic; a zero divisor magnitude means the divisor itself was zero
  always_comb begin
    busy          = (state_q != IDLE);
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    if (accept) begin
      div_by_zero_d = 1'b0;
      overflow_d    = 1'b0;
    end else if (state_q == FIX) begin
      done_d = 1'b1;
      if (dvs_q == '0) begin
        quotient_d    = '1;
        remainder_d   = dvd_raw_q;
        div_by_zero_d = 1'b1;
      end else begin
        quotient_d  = neg_q_q ? negate(quo_q) : quo_q;
        remainder_d = neg_r_q ? negate(part_q[WIDTH-1:0]) : part_q[WIDTH-1:0];
        overflow_d  = ovf_pend_q;
      end
    end
  end

  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=16): vector table plus hand-written
// sequences for start-during-run, back-to-back start and mid-run reset.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands for one edge; returns 1 ns after the accepting edge
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; n = edges after the accepting edge, bcnt = busy cycles
  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n, bcnt;
    logic saw_done;

    vecs[0]  = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17};
    vecs[1]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[2]  = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17};
    vecs[3]  = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1};
    vecs[4]  = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 17};
    vecs[6]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 17};
    vecs[7]  = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
    vecs[9]  = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
    vecs[10] = '{1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 17};
    vecs[11] = '{1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 1'b0, 17};

    rst_n = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d flags cleared on accept", i), 32'({div_by_zero, overflow}), 32'd0);
      wait_done(n, bcnt);
      chk($sformatf("v%0d latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      chk($sformatf("v%0d busy with done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d div_by_zero", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      @(posedge clk); #1;
      chk($sformatf("v%0d done pulse width", i), 32'(done), 32'd0);
      chk($sformatf("v%0d quotient hold", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d div_by_zero hold", i), 32'(div_by_zero), 32'(vecs[i].dbz));
    end

    // start pulsed mid-run is ignored; start held through done is taken at once
    issue(1'b0, 16'd100, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 16'd50;
    divisor = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore start: busy", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    signed_op = 1'b0;
    dividend = 16'd1000;
    divisor = 16'd10;
    @(posedge clk); #1;
    chk("ignore start: no early done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("ignore start: done at E17", 32'(done), 32'd1);
    chk("ignore start: quotient", 32'(quotient), 32'd14);
    chk("ignore start: remainder", 32'(remainder), 32'd2);
    @(posedge clk); #1;
    start = 1'b0;
    chk("back-to-back: busy", 32'(busy), 32'd1);
    chk("back-to-back: done fell", 32'(done), 32'd0);
    chk("back-to-back: quotient held", 32'(quotient), 32'd14);
    wait_done(n, bcnt);
    chk("back-to-back: latency", 32'(n), 32'd17);
    chk("back-to-back: quotient", 32'(quotient), 32'd100);
    chk("back-to-back: remainder", 32'(remainder), 32'd0);

    // Reset at E8 aborts the operation with no done
    issue(1'b0, 16'd100, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid-run reset: busy", 32'(busy), 32'd0);
    chk("mid-run reset: done", 32'(done), 32'd0);
    chk("mid-run reset: quotient", 32'(quotient), 32'd0);
    chk("mid-run reset: remainder", 32'(remainder), 32'd0);
    chk("mid-run reset: flags", 32'({div_by_zero, overflow}), 32'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("mid-run reset: stays idle", 32'(saw_done), 32'd0);
    issue(1'b0, 16'hFFFF, 16'h0001);
    wait_done(n, bcnt);
    chk("after reset: latency", 32'(n), 32'd17);
    chk("after reset: quotient", 32'(quotient), 32'hFFFF);
    chk("after reset: remainder", 32'(remainder), 32'd0);

    // Overflow flag must drop on the next accepted start
    issue(1'b1, 16'h8000, 16'hFFFF);
    wait_done(n, bcnt);
    chk("ovf set", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 16'd9, 16'd3);
    chk("ovf cleared on accept", 32'(overflow), 32'd0);
    wait_done(n, bcnt);
    chk("ovf follow-up quotient", 32'(quotient), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
